// File: rtl/seq_restoring_divider_16by8_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e   : FSM state encoding (Idle / Calc / Done, 2 bits)
//   cnt_width : iteration counter width for a given divisor width
//   pad4      : round a width up to a whole number of 4-bit lookahead groups
package seq_restoring_divider_16by8_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must reach 2*data_width-1.
  function automatic int unsigned cnt_width(input int unsigned data_width);
    return $clog2(2 * data_width);
  endfunction

  function automatic int unsigned pad4(input int unsigned w);
    return ((w + 3) / 4) * 4;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_16by8_cla_sub.sv
// Carry-lookahead subtractor: diff_o = a_i - b_i, computed as a_i + ~b_i + 1.
// The operands are padded to a multiple of 4 bits and each 4-bit group
// resolves its carries with full lookahead; groups chain through their
// group generate/propagate terms.
//   a_i         : minuend
//   b_i         : subtrahend
//   diff_o      : a_i - b_i (modulo 2^Width)
//   no_borrow_o : 1 when a_i >= b_i (carry out of the add)
module seq_restoring_divider_16by8_cla_sub
  import seq_restoring_divider_16by8_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             no_borrow_o
);

  localparam int unsigned PadW    = pad4(Width);
  localparam int unsigned NGroups = PadW / 4;

  logic [PadW-1:0]  a_pad;
  logic [PadW-1:0]  b_inv;
  logic [PadW-1:0]  g;
  logic [PadW-1:0]  p;
  logic [PadW-1:0]  c;
  logic [PadW-1:0]  sum;
  logic [NGroups:0] gc;

  // Padding bits: a=0, ~b=1, so each pad position just propagates the carry
  // and the final group carry equals the carry out of bit Width-1.
  always_comb begin
    a_pad             = '0;
    a_pad[Width-1:0]  = a_i;
    b_inv             = '1;
    b_inv[Width-1:0]  = ~b_i;
  end

  assign g     = a_pad & b_inv;
  assign p     = a_pad ^ b_inv;
  assign gc[0] = 1'b1;

  for (genvar grp = 0; grp < NGroups; grp++) begin : g_group
    localparam int unsigned B = 4 * grp;
    logic grp_g;
    logic grp_p;

    assign c[B]   = gc[grp];
    assign c[B+1] = g[B] | (p[B] & gc[grp]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[grp]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[grp]);

    assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p = &p[B+3:B];

    assign gc[grp+1] = grp_g | (grp_p & gc[grp]);
  end

  assign sum         = p ^ c;
  assign diff_o      = sum[Width-1:0];
  assign no_borrow_o = gc[NGroups];

  if (PadW > Width) begin : g_pad_sink
    logic unused_pad_sum;
    assign unused_pad_sum = ^sum[PadW-1:Width];
  end

endmodule

// File: rtl/seq_restoring_divider_16by8.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// (2*DATA_WIDTH)-bit dividend / DATA_WIDTH-bit divisor with valid/ready on
// both the operand and result sides. All outputs are registered.
//   clk, rst     : clock, synchronous active-high reset
//   inData_A     : dividend
//   inData_B     : divisor
//   inValid      : operands valid
//   inReady      : divider can accept operands (only in Idle)
//   outQuotient  : quotient (all ones on divide by zero)
//   outRemainder : remainder (zero on divide by zero)
//   divByZero    : result came from a zero divisor
//   outValid     : result valid, held until outReady
//   outReady     : consumer accepts result
module seq_restoring_divider_16by8
  import seq_restoring_divider_16by8_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] inData_A,
  input  logic [DATA_WIDTH-1:0]   inData_B,
  input  logic                    inValid,
  output logic                    inReady,
  output logic [2*DATA_WIDTH-1:0] outQuotient,
  output logic [DATA_WIDTH-1:0]   outRemainder,
  output logic                    divByZero,
  output logic                    outValid,
  input  logic                    outReady
);

  localparam int unsigned QW = 2 * DATA_WIDTH;
  localparam int unsigned RW = DATA_WIDTH + 1;
  localparam int unsigned CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(QW - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [QW-1:0]     q_q, q_d;
  logic [RW-1:0]     r_q, r_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [QW-1:0]     quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic              valid_q, valid_d;
  logic              in_ready_q, in_ready_d;

  logic [RW-1:0]     shifted;
  logic [RW-1:0]     trial;
  logic              no_borrow;

  // Partial remainder stays below the divisor, so its MSB only matters
  // transiently inside the shifted value.
  assign shifted = {r_q[DATA_WIDTH-1:0], q_q[QW-1]};

  seq_restoring_divider_16by8_cla_sub #(
    .Width (RW)
  ) u_sub (
    .a_i         (shifted),
    .b_i         ({1'b0, d_q}),
    .diff_o      (trial),
    .no_borrow_o (no_borrow)
  );

  logic unused_r_msb;
  assign unused_r_msb = r_q[DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        if (inValid && in_ready_q) begin
          if (inData_B == '0) begin
            // Result is known immediately; outValid follows one edge later.
            state_d = StDone;
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = StCalc;
            q_d     = inData_A;
            d_d     = inData_B;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end
        end
      end
      StCalc: begin
        q_d   = {q_q[QW-2:0], no_borrow};
        r_d   = no_borrow ? trial : shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          quot_d  = q_d;
          rem_d   = r_d[DATA_WIDTH-1:0];
          valid_d = 1'b1;
        end
      end
      StDone: begin
        valid_d = 1'b1;
        if (valid_q && outReady) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      d_q        <= d_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign inReady      = in_ready_q;
  assign outQuotient  = quot_q;
  assign outRemainder = rem_q;
  assign divByZero    = dbz_q;
  assign outValid     = valid_q;

endmodule

// File: doc/seq_restoring_divider_16by8.md
Name: seq_restoring_divider_16by8

Overview:
- Iterative unsigned restoring divider: (2*DATA_WIDTH)-bit dividend / DATA_WIDTH-bit divisor, one quotient bit per clock.
- Inverse datapath of the multiplier/adder chain. The trial subtraction each cycle uses a carry-lookahead subtractor (add of inverted divisor, cin=1).
- Valid/ready handshake on both the operand side and the result side, so it can sit behind the multiplier test harness or any producer.

Parameters:
- DATA_WIDTH, 8, divisor/remainder width; dividend and quotient are 2*DATA_WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- inData_A  input  2*DATA_WIDTH  dividend
- inData_B  input  DATA_WIDTH  divisor
- inValid  input  1  operands valid
- inReady  output  1  divider can accept operands
- outQuotient  output  2*DATA_WIDTH  quotient
- outRemainder  output  DATA_WIDTH  remainder
- divByZero  output  1  result came from a zero divisor
- outValid  output  1  result valid
- outReady  input  1  consumer accepts result

Behaviour:
- One clock domain, clk. rst is synchronous active-high and is sampled only on the rising edge of clk.
- Reset values: state=IDLE, inReady=1, outValid=0, outQuotient=0, outRemainder=0, divByZero=0, iteration counter=0.
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE:
  - inReady=1.
  - On inValid&inReady and inData_B!=0: latch dividend into shift reg Q, latch divisor into D, clear partial remainder R (DATA_WIDTH+1 bits), counter=0, clear divByZero, go to CALC.
  - On inValid&inReady and inData_B==0: go directly to DONE with outQuotient=all ones, outRemainder=0, divByZero=1. outValid rises 1 edge after the accept edge.
- CALC (inReady=0), each cycle:
  - shifted = {R[DATA_WIDTH-1:0], Q[MSB]}.
  - trial = shifted - {1'b0,D} via subtractor.
  - If no borrow (carry out=1): R=trial, shift 1 into Q LSB. Otherwise R=shifted, shift 0 into Q LSB.
  - counter increments each cycle.
  - After the 2*DATA_WIDTH-th iteration (counter==2*DATA_WIDTH-1): go to DONE. In the same edge, load outQuotient=final Q and outRemainder=final R[DATA_WIDTH-1:0], and set outValid=1.
  - Latency: outValid high exactly 2*DATA_WIDTH (16) edges after the accept edge.
- DONE:
  - outValid=1. Outputs are held stable while outReady=0 (backpressure of any length).
  - On outValid&outReady: outValid=0, go to IDLE.
  - inReady stays 0 until back in IDLE. Minimum issue interval is therefore 18 cycles.
- Arithmetic rules:
  - Everything is unsigned.
  - R never exceeds D-1 after an iteration, so remainder fits DATA_WIDTH.
  - Quotient may be the full 2*DATA_WIDTH bits.
- Boundary behaviour:
  - inValid while busy is ignored; no latch, no corruption.
  - Operand inputs may change freely after the accept edge.
  - rst asserted in any state, including mid-CALC or in DONE with a pending result: the next edge returns all registers to reset values and the in-flight result is discarded.
  - Dividend < divisor gives quotient 0, remainder = dividend.
- Synthesizable Verilog-2001. No latches; all outputs are registered.

Decomposition:
- Shared include file div_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - counter width localparam (clog2 of 2*DATA_WIDTH).
- One natural sub-module, cla_subtractor_nbit, parameterized width (DATA_WIDTH+1):
  - inputs A, B; outputs diff and noBorrow;
  - built as a carry-lookahead add of A + ~B + 1 using the existing 4-bit lookahead block style, width padded to a multiple of 4.
- The divider top holds only the FSM, the counter and the Q/R/D registers.

Test Plan:
- 1000 / 7 -> after 16 cycles outQuotient=142, outRemainder=6, divByZero=0, outValid=1.
- 65535 / 255 -> outQuotient=257, outRemainder=0. Also 65535 / 1 -> outQuotient=65535, outRemainder=0.
- 100 / 200 -> outQuotient=0, outRemainder=100.
- 5 / 0 -> outValid one edge after accept, outQuotient=16'hFFFF, outRemainder=0, divByZero=1.
- Backpressure: hold outReady=0 for 10 cycles -> outputs and outValid stable, inReady=0. Pulse outReady -> IDLE next edge, inReady=1. Then a back-to-back second operation produces the correct result.
- Reset mid-CALC (rst at iteration 8) -> next edge all outputs at reset values, inReady=1. A following 1000/7 still yields 142 r 6.
